subtractor_400bit_seq: RTL and testbench

Sequential 400-bit unsigned multi-precision subtractor computing diff = a - b one 8-bit limb per clock, LSB limb first, with a 1-bit borrow chain.
- Inverse-direction companion to the team's 400-bit limb adder; same flat operand format.
- Used by the big-integer datapath to undo additions and to compare operands (borrow_out = a < b).
- Start/done handshake with a busy flag; operands are captured at start, so the caller may change inputs immediately afterwards.

---
 rtl/subtractor_400bit_seq.sv | 155 +++++++++++++++
 tb/tb_subtractor_400bit_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/subtractor_400bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : subtractor_400bit_seq
// Brief    : Sequential multi-precision unsigned subtractor. Computes
//            diff = a - b one LIMB-bit limb per clock, LSB limb first, with a
//            single-bit borrow chain. Operands are captured on an accepted
//            start so the caller may change them right away. The final borrow
//            doubles as an a < b comparison result.
// Revision : 1.0 - initial release
// ============================================================================
module subtractor_400bit_seq #(
  parameter int WIDTH = 400,
  parameter int LIMB  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_flat,
  input  logic [WIDTH-1:0] b_flat,
  output logic [WIDTH-1:0] diff_flat,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int NLIMB = WIDTH / LIMB;
  localparam int IDXW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NLIMB - 1);
  localparam logic [IDXW-1:0] C_IDX_ONE  = IDXW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Captured operands; held stable for the whole operation.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  // Result register; limbs are filled in LSB-first as the chain ripples.
  logic [WIDTH-1:0] diff_q, diff_d;

  logic [IDXW-1:0]  idx_q, idx_d;
  logic             borrow_q, borrow_d;
  logic             borrow_out_q, borrow_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Current limb operands and the LIMB+1-bit limb difference.
  logic [LIMB-1:0]  w_a_limb;
  logic [LIMB-1:0]  w_b_limb;
  logic [LIMB:0]    w_sub;

  // Select the limb pair addressed by the running index.
  always_comb begin
    w_a_limb = '0;
    w_b_limb = '0;
    for (int i = 0; i < NLIMB; i++) begin
      if (idx_q == IDXW'(i)) begin
        w_a_limb = a_q[i*LIMB +: LIMB];
        w_b_limb = b_q[i*LIMB +: LIMB];
      end
    end
  end

  // One limb of subtraction; the MSB of the widened result is the borrow out.
  assign w_sub = {1'b0, w_a_limb} - {1'b0, w_b_limb} - {{LIMB{1'b0}}, borrow_q};

  // Next-state logic: accept a start in IDLE, walk the limbs in RUN.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    idx_d        = idx_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d          = a_flat;
          b_d          = b_flat;
          idx_d        = '0;
          borrow_d     = 1'b0;
          diff_d       = '0;
          borrow_out_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = ST_RUN;
        end
      end

      ST_RUN: begin
        for (int i = 0; i < NLIMB; i++) begin
          if (idx_q == IDXW'(i)) begin
            diff_d[i*LIMB +: LIMB] = w_sub[LIMB-1:0];
          end
        end
        borrow_d = w_sub[LIMB];
        idx_d    = idx_q + C_IDX_ONE;

        // Last limb: publish the final borrow and hand back to IDLE.
        if (idx_q == C_LAST_IDX) begin
          borrow_out_d = w_sub[LIMB];
          done_d       = 1'b1;
          busy_d       = 1'b0;
          idx_d        = '0;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      idx_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      idx_q        <= idx_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign diff_flat  = diff_q;
  assign borrow_out = borrow_out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_subtractor_400bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtractor_400bit_seq
// Brief    : Self-checking bench for subtractor_400bit_seq. Expected results
//            come from whole-word 401-bit arithmetic on the operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subtractor_400bit_seq;

  localparam int W     = 400;
  localparam int NLIMB = 50;
  localparam int BOUND = 200;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_flat;
  logic [W-1:0] b_flat;
  logic [W-1:0] diff_flat;
  logic         borrow_out;
  logic         busy;
  logic         done;

  int n_cmp;
  int n_err;

  subtractor_400bit_seq #(.WIDTH(W), .LIMB(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .diff_flat  (diff_flat),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 13; i++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  // Reference: exact (a - b) over W+1 bits; top bit is the borrow.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
    a_flat = a;
    b_flat = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Wait for done with a cycle budget; also count cycles where busy dropped early.
  task automatic wait_done(output int cycles, output int busy_low);
    cycles   = 0;
    busy_low = 0;
    do begin
      tick();
      cycles++;
      if (!done && !busy) busy_low++;
    end while (!done && cycles < BOUND);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc, bl;
    logic [W:0] r;
    r = ref_sub(a, b);
    pulse_start(a, b);
    wait_done(cyc, bl);
    check({tag, "_latency"}, W'(cyc), W'(NLIMB));
    check({tag, "_diff"}, diff_flat, r[W-1:0]);
    check({tag, "_borrow"}, W'(borrow_out), W'(r[W]));
  endtask

  initial begin
    int cyc, bl, ndone, done_at;
    logic [W-1:0] a0, b0, x, got_diff;
    logic got_borrow;
    logic [W:0] r;

    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a_flat = '0;
    b_flat = '0;

    // Reset state
    tick();
    tick();
    check("rst_diff", diff_flat, '0);
    check("rst_borrow", W'(borrow_out), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    rst = 1'b0;
    tick();

    // 5 - 1 with busy monitoring
    pulse_start(W'(5), W'(1));
    check("t1_busy_after_start", W'(busy), W'(1));
    check("t1_done_after_start", W'(done), '0);
    wait_done(cyc, bl);
    check("t1_latency", W'(cyc), W'(NLIMB));
    check("t1_busy_gaps", W'(bl), '0);
    check("t1_busy_at_done", W'(busy), '0);
    check("t1_diff", diff_flat, W'(4));
    check("t1_borrow", W'(borrow_out), '0);
    tick();
    check("t1_done_one_pulse", W'(done), '0);

    // Full borrow ripple, inter-limb borrow, equal operands
    run_op("zero_minus_one", '0, W'(1));
    check("all_ones", diff_flat, {W{1'b1}});
    run_op("inter_limb", W'(256), W'(1));
    check("inter_limb_ff", diff_flat, W'(255));
    x = rand_op();
    run_op("equal", x, x);
    check("equal_zero", diff_flat, '0);
    run_op("max_minus_max", {W{1'b1}}, {W{1'b1}});

    // Operand change and start during RUN are ignored
    a0 = rand_op();
    b0 = rand_op();
    r  = ref_sub(a0, b0);
    pulse_start(a0, b0);
    ndone   = 0;
    done_at = 0;
    got_diff   = '0;
    got_borrow = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 11) begin
        a_flat = rand_op();
        b_flat = rand_op();
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        ndone++;
        if (done_at == 0) begin
          done_at    = c;
          got_diff   = diff_flat;
          got_borrow = borrow_out;
        end
      end
    end
    start = 1'b0;
    check("ignore_done_count", W'(ndone), W'(1));
    check("ignore_latency", W'(done_at), W'(NLIMB));
    check("ignore_diff", got_diff, r[W-1:0]);
    check("ignore_borrow", W'(got_borrow), W'(r[W]));

    // Reset mid-operation aborts without a done
    pulse_start(rand_op(), rand_op());
    for (int c = 0; c < 25; c++) tick();
    rst = 1'b1;
    tick();
    check("abort_diff", diff_flat, '0);
    check("abort_borrow", W'(borrow_out), '0);
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("abort_no_activity", W'(ndone), '0);
    run_op("after_abort", W'(1000), W'(7));

    // 200 random pairs, each new start issued in the previous done cycle
    a0 = rand_op();
    b0 = rand_op();
    pulse_start(a0, b0);
    for (int n = 0; n < 200; n++) begin
      wait_done(cyc, bl);
      r = ref_sub(a0, b0);
      check($sformatf("b2b%0d_latency", n), W'(cyc), W'(NLIMB));
      check($sformatf("b2b%0d_diff", n), diff_flat, r[W-1:0]);
      check($sformatf("b2b%0d_borrow", n), W'(borrow_out), W'(r[W]));
      if (cyc >= BOUND) break;
      if (n < 199) begin
        a0 = rand_op();
        b0 = ($urandom_range(0, 7) == 0) ? a0 : rand_op();
        pulse_start(a0, b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
